// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave / RAM controller pair:
// command opcodes, default sizes and the rx word layout.
package spi_pkg;

    localparam int unsigned DEF_MEM_DEPTH = 256;
    localparam int unsigned DEF_ADDR_SIZE = 8;
    localparam int unsigned DEF_TX_HOLD   = 10;
    localparam int unsigned DATA_W        = 8;
    localparam int unsigned RX_W          = 10;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef struct packed {
        cmd_e              op;
        logic [DATA_W-1:0] payload;
    } rx_word_t;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Parallel word link between the SPI slave (master side) and the RAM controller (slave side).
interface spi_ram_ctrl_if;

    logic [spi_pkg::RX_W-1:0]   rx_data;
    logic                       rx_valid;
    logic [spi_pkg::DATA_W-1:0] tx_data;
    logic                       tx_valid;
    logic                       err;

    modport master (
        output rx_data, rx_valid,
        input  tx_data, tx_valid, err
    );

    modport slave (
        input  rx_data, rx_valid,
        output tx_data, tx_valid, err
    );

endinterface

// File: rtl/spi_ram_array.sv
// Byte-wide storage: synchronous write, combinational read, contents not reset.
module spi_ram_array
    import spi_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_SIZE-1:0] waddr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    input  logic [ADDR_SIZE-1:0] raddr_i,
    output logic [DATA_W-1:0]    rdata_c_o
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[IDX_W'(waddr_i)] <= wdata_i;
        end
    end

    assign rdata_c_o = mem_q[IDX_W'(raddr_i)];

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder in front of the RAM array: edge-triggered command acceptance,
// auto-incrementing pointers, read-return hold window and error pulse.
module spi_ram_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int unsigned TX_HOLD   = DEF_TX_HOLD
) (
    input  logic           clk,
    input  logic           rst,
    spi_ram_ctrl_if.slave  bus
);

    localparam int unsigned HOLD_W = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;

    rx_word_t              cmd;
    logic [ADDR_SIZE-1:0]  cmd_addr;
    logic                  addr_ok;
    logic                  accept;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  rx_valid_q;
    logic [ADDR_SIZE-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [ADDR_SIZE-1:0]  rd_ptr_q,   rd_ptr_d;
    logic                  wr_armed_q, wr_armed_d;
    logic                  rd_armed_q, rd_armed_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [DATA_W-1:0]     tx_data_q,  tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  err_q,      err_d;

    function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
        return (32'(p) == MEM_DEPTH - 1) ? '0 : p + ADDR_SIZE'(1);
    endfunction

    assign cmd      = rx_word_t'(bus.rx_data);
    assign cmd_addr = cmd.payload[ADDR_SIZE-1:0];
    assign addr_ok  = 32'(cmd_addr) < MEM_DEPTH;
    assign accept   = bus.rx_valid && !rx_valid_q;

    spi_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk       (clk),
        .we_i      (mem_we),
        .waddr_i   (wr_ptr_q),
        .wdata_i   (cmd.payload),
        .raddr_i   (rd_ptr_q),
        .rdata_c_o (mem_rdata)
    );

    // Any accepted command closes the hold window; only a successful read reopens it.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_armed_d = wr_armed_q;
        rd_armed_d = rd_armed_q;
        hold_cnt_d = hold_cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        err_d      = 1'b0;
        mem_we     = 1'b0;

        if (tx_valid_q) begin
            if (hold_cnt_q == '0) begin
                tx_valid_d = 1'b0;
            end else begin
                hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end
        end

        if (accept) begin
            tx_valid_d = 1'b0;
            unique case (cmd.op)
                CMD_WR_ADDR: begin
                    if (addr_ok) begin
                        wr_ptr_d   = cmd_addr;
                        wr_armed_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_WR_DATA: begin
                    if (wr_armed_q) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_RD_ADDR: begin
                    if (addr_ok) begin
                        rd_ptr_d   = cmd_addr;
                        rd_armed_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_RD_DATA: begin
                    if (rd_armed_q) begin
                        tx_data_d  = mem_rdata;
                        tx_valid_d = 1'b1;
                        hold_cnt_d = HOLD_W'(TX_HOLD - 1);
                        rd_ptr_d   = ptr_inc(rd_ptr_q);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_armed_q <= 1'b0;
            rd_armed_q <= 1'b0;
            hold_cnt_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rx_valid_q <= bus.rx_valid;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_armed_q <= wr_armed_d;
            rd_armed_q <= rd_armed_d;
            hold_cnt_q <= hold_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: a 256-deep and a 128-deep instance driven with the same
// command stream, each checked every cycle against a transaction-level model.
module tb_spi_ram_ctrl;
    import spi_pkg::*;

    localparam int TX_HOLD = 10;

    logic clk;
    logic rst;

    spi_ram_ctrl_if bus_a ();
    spi_ram_ctrl_if bus_b ();

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .TX_HOLD(TX_HOLD)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    spi_ram_ctrl #(.MEM_DEPTH(128), .ADDR_SIZE(8), .TX_HOLD(TX_HOLD)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: array contents plus pointers; the read window is kept as
    // the last cycle number on which tx_valid is expected high.
    int         dep [2] = '{256, 128};
    logic [7:0] m_mem   [2][256];
    bit         m_known [2][256];
    int         m_wp [2];
    int         m_rp [2];
    bit         m_wa [2];
    bit         m_ra [2];
    logic [7:0] m_txd [2];
    bit         m_txd_known [2];
    int         m_until [2];
    bit         m_err [2];
    bit         m_prev [2];
    int         cyc = 0;

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_wp[i] = 0;  m_rp[i] = 0;
            m_wa[i] = 0;  m_ra[i] = 0;
            m_txd[i] = 8'h00;  m_txd_known[i] = 1'b1;
            m_until[i] = cyc - 1;
            m_err[i] = 0;  m_prev[i] = 0;
        end
    endfunction

    function automatic void model_edge(input bit rv, input logic [9:0] d);
        int pl;
        cyc++;
        pl = int'(d[7:0]);
        for (int i = 0; i < 2; i++) begin
            m_err[i] = 1'b0;
            if (rv && !m_prev[i]) begin
                m_until[i] = cyc - 1;
                case (d[9:8])
                    CMD_WR_ADDR: if (pl < dep[i]) begin m_wp[i] = pl; m_wa[i] = 1; end
                                 else m_err[i] = 1;
                    CMD_WR_DATA: if (m_wa[i]) begin
                                     m_mem[i][m_wp[i]]   = d[7:0];
                                     m_known[i][m_wp[i]] = 1'b1;
                                     m_wp[i] = (m_wp[i] + 1) % dep[i];
                                 end else m_err[i] = 1;
                    CMD_RD_ADDR: if (pl < dep[i]) begin m_rp[i] = pl; m_ra[i] = 1; end
                                 else m_err[i] = 1;
                    default:     if (m_ra[i]) begin
                                     m_txd[i]       = m_mem[i][m_rp[i]];
                                     m_txd_known[i] = m_known[i][m_rp[i]];
                                     m_rp[i]        = (m_rp[i] + 1) % dep[i];
                                     m_until[i]     = cyc + TX_HOLD - 1;
                                 end else m_err[i] = 1;
                endcase
            end
            m_prev[i] = rv;
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("a_tx_valid", {7'b0, bus_a.tx_valid}, {7'b0, (cyc <= m_until[0])});
        chk("b_tx_valid", {7'b0, bus_b.tx_valid}, {7'b0, (cyc <= m_until[1])});
        chk("a_err", {7'b0, bus_a.err}, {7'b0, m_err[0]});
        chk("b_err", {7'b0, bus_b.err}, {7'b0, m_err[1]});
        if (m_txd_known[0]) chk("a_tx_data", bus_a.tx_data, m_txd[0]);
        if (m_txd_known[1]) chk("b_tx_data", bus_b.tx_data, m_txd[1]);
    endtask

    task automatic tick(input bit rv, input logic [9:0] d);
        bus_a.rx_valid = rv;  bus_a.rx_data = d;
        bus_b.rx_valid = rv;  bus_b.rx_data = d;
        @(posedge clk);
        model_edge(rv, d);
        #1;
        compare_all();
    endtask

    task automatic cmd(input logic [1:0] op, input logic [7:0] pl);
        tick(1'b1, {op, pl});
        tick(1'b0, {op, pl});
    endtask

    initial begin
        int hi_cnt;
        int nhi;
        int nlo;
        logic [9:0] rw;

        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 256; a++) m_known[i][a] = 1'b0;

        rst = 1'b1;
        bus_a.rx_valid = 1'b0;  bus_a.rx_data = '0;
        bus_b.rx_valid = 1'b0;  bus_b.rx_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_tx_valid", {7'b0, bus_a.tx_valid}, 8'h00);
        chk("rst_a_tx_data",  bus_a.tx_data, 8'h00);
        chk("rst_a_err",      {7'b0, bus_a.err}, 8'h00);
        chk("rst_b_tx_valid", {7'b0, bus_b.tx_valid}, 8'h00);
        rst = 1'b0;

        // Read without an armed read pointer.
        tick(1'b1, {CMD_RD_DATA, 8'h00});
        chk("t1_err", {7'b0, bus_a.err}, 8'h01);
        tick(1'b0, {CMD_RD_DATA, 8'h00});
        chk("t1_err_gone", {7'b0, bus_a.err}, 8'h00);
        chk("t1_tx_valid", {7'b0, bus_a.tx_valid}, 8'h00);

        // Fill the whole array so every later read has a known value.
        cmd(CMD_WR_ADDR, 8'h00);
        for (int k = 0; k < 256; k++) cmd(CMD_WR_DATA, 8'($urandom));

        // Sequential write then sequential read-back.
        cmd(CMD_WR_ADDR, 8'h10);
        cmd(CMD_WR_DATA, 8'hA5);
        cmd(CMD_WR_DATA, 8'h3C);
        cmd(CMD_RD_ADDR, 8'h10);
        tick(1'b1, {CMD_RD_DATA, 8'h00});
        chk("t2_rd0_valid", {7'b0, bus_a.tx_valid}, 8'h01);
        chk("t2_rd0_data", bus_a.tx_data, 8'hA5);
        tick(1'b0, {CMD_RD_DATA, 8'h00});
        tick(1'b1, {CMD_RD_DATA, 8'h00});
        chk("t2_rd1_valid", {7'b0, bus_a.tx_valid}, 8'h01);
        chk("t2_rd1_data", bus_a.tx_data, 8'h3C);
        chk("t2_b_rd1_data", bus_b.tx_data, 8'h3C);
        tick(1'b0, {CMD_RD_DATA, 8'h00});

        // Write pointer wraps from the top address to 0.
        cmd(CMD_WR_ADDR, 8'hFF);
        cmd(CMD_WR_DATA, 8'h11);
        cmd(CMD_WR_DATA, 8'h22);
        cmd(CMD_RD_ADDR, 8'h00);
        cmd(CMD_RD_DATA, 8'h00);
        chk("t3_wrap_data", bus_a.tx_data, 8'h22);

        // Level held high: one read, full hold window.
        hi_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1'b1, {CMD_RD_DATA, 8'h00});
            if (bus_a.tx_valid) hi_cnt++;
        end
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, {CMD_RD_DATA, 8'h00});
            if (bus_a.tx_valid) hi_cnt++;
        end
        chk("t4_hold_len", 8'(hi_cnt), 8'(TX_HOLD));
        cmd(CMD_RD_DATA, 8'h00);
        chk("t4_next_addr", bus_a.tx_data, m_mem[0][2]);

        // Out-of-range read address on the 128-deep instance.
        cmd(CMD_WR_ADDR, 8'h7F);
        cmd(CMD_WR_DATA, 8'h5A);
        cmd(CMD_RD_ADDR, 8'h7F);
        cmd(CMD_RD_DATA, 8'h00);
        chk("t5_b_data", bus_b.tx_data, 8'h5A);
        tick(1'b1, {CMD_RD_ADDR, 8'h80});
        chk("t5_b_err", {7'b0, bus_b.err}, 8'h01);
        chk("t5_a_err", {7'b0, bus_a.err}, 8'h00);
        tick(1'b0, {CMD_RD_ADDR, 8'h80});
        cmd(CMD_RD_DATA, 8'h00);
        chk("t5_b_ptr_kept", bus_b.tx_data, m_mem[1][0]);

        // Random command stream with random level lengths and gaps.
        for (int k = 0; k < 300; k++) begin
            rw  = 10'($urandom);
            nhi = $urandom_range(1, 3);
            nlo = $urandom_range(1, 3);
            for (int j = 0; j < nhi; j++) tick(1'b1, rw);
            for (int j = 0; j < nlo; j++) tick(1'b0, rw);
        end

        // Asynchronous reset in the middle of a hold window.
        cmd(CMD_RD_ADDR, 8'h05);
        tick(1'b1, {CMD_RD_DATA, 8'h00});
        tick(1'b0, {CMD_RD_DATA, 8'h00});
        tick(1'b0, {CMD_RD_DATA, 8'h00});
        chk("t6_pre_valid", {7'b0, bus_a.tx_valid}, 8'h01);
        rst = 1'b1;
        #1;
        chk("t6_a_async_valid", {7'b0, bus_a.tx_valid}, 8'h00);
        chk("t6_b_async_valid", {7'b0, bus_b.tx_valid}, 8'h00);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1'b1, {CMD_WR_DATA, 8'h77});
        chk("t6_wr_disarmed", {7'b0, bus_a.err}, 8'h01);
        tick(1'b0, {CMD_WR_DATA, 8'h77});
        cmd(CMD_RD_DATA, 8'h00);
        cmd(CMD_WR_ADDR, 8'h00);
        cmd(CMD_RD_ADDR, 8'h00);
        cmd(CMD_RD_DATA, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Single-port RAM plus command decoder. Sits directly downstream of the SPI slave.
- Consumes the slave's 10-bit parallel words (rx_data/rx_valid). Bits [9:8] select the command; bits [7:0] carry the address or data.
- Returns read data to the slave as tx_data/tx_valid for serialisation onto MISO.
- Adds address auto-increment, a read-return hold window and error flagging.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words in the array.
- ADDR_SIZE, 8, width of the address field; only the low ADDR_SIZE bits of the payload are used.
- TX_HOLD, 10, number of cycles tx_valid stays asserted after a read-data command.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  10  command word from the SPI slave: [9:8] opcode, [7:0] payload.
- rx_valid  in  1  rx_data valid; level signal, may stay high for many cycles.
- tx_data  out  8  read data to the SPI slave.
- tx_valid  out  1  tx_data valid.
- err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset (async, rst=1):
  - tx_data=0, tx_valid=0, err=0.
  - wr_ptr=0, rd_ptr=0, wr_armed=0, rd_armed=0, hold_cnt=0, rx_valid_q=0.
  - Memory contents are not reset.
- Command acceptance:
  - A command is accepted only on a rising edge of rx_valid: rx_valid=1 and rx_valid_q=0, where rx_valid_q is rx_valid registered.
  - A level held high executes exactly once. Any other cycle is idle.
- Opcodes (rx_data[9:8]):
  - 00 WR_ADDR: wr_ptr <= payload; wr_armed <= 1.
  - 01 WR_DATA: if wr_armed, mem[wr_ptr] <= payload and wr_ptr increments. Otherwise no write and err pulses.
  - 10 RD_ADDR: rd_ptr <= payload; rd_armed <= 1.
  - 11 RD_DATA: if rd_armed, tx_data <= mem[rd_ptr], tx_valid <= 1, hold_cnt <= TX_HOLD-1, and rd_ptr increments. Otherwise err pulses and tx_data/tx_valid are unchanged.
- Range check: a WR_ADDR or RD_ADDR payload >= MEM_DEPTH is rejected. Pointer and armed flag are unchanged, and err pulses the next cycle.
- Pointer wrap: incrementing from MEM_DEPTH-1 wraps to 0.
- Latency:
  - RD_DATA edge at cycle N gives tx_valid=1 and tx_data valid from cycle N+1.
  - A write is visible to RD_DATA from cycle N+1.
  - err is high for exactly cycle N+1.
- Hold window:
  - While tx_valid=1 and no new command is accepted, hold_cnt decrements each cycle.
  - tx_valid clears on the cycle after hold_cnt reaches 0, giving TX_HOLD cycles high in total.
  - tx_data holds its value after tx_valid drops.
- Simultaneous events:
  - A command accepted during the hold window ends it: tx_valid drops next cycle.
  - Exception: if that command is RD_DATA, tx_data and tx_valid reload and hold_cnt restarts.
- Read-after-write: RD_DATA on the same address as a write accepted in the previous cycle returns the new data (no bypass needed; commands are at least 2 cycles apart).
- Armed flags stay set until reset.
- Reset mid-hold: tx_valid drops immediately (asynchronously).

Decomposition:
- Shared package spi_pkg:
  - opcode constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - default MEM_DEPTH and ADDR_SIZE, for reuse by the slave and the top level.
- Sub-module spi_ram_array: MEM_DEPTH x 8 storage with synchronous write port and combinational read by address, no reset.
- The controller holds the pointers, edge detect, armed flags, hold counter and err.

Test Plan:
- Reset then RD_DATA edge with no RD_ADDR -> err high for one cycle, tx_valid stays 0.
- WR_ADDR 0x10, then WR_DATA 0xA5, then WR_DATA 0x3C, then RD_ADDR 0x10 and two RD_DATA edges:
  - first returns tx_data=0xA5, second returns 0x3C.
  - tx_valid rises 1 cycle after each edge.
- WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22, then RD_ADDR 0x00, RD_DATA -> tx_data=0x22, confirming wrap.
- RD_DATA with rx_valid held high for 20 cycles:
  - one read only; rd_ptr advances by 1.
  - tx_valid high for exactly 10 cycles (TX_HOLD=10).
- MEM_DEPTH=128, RD_ADDR 0x80 -> err pulse, rd_ptr unchanged. A following RD_DATA returns the previous address's data.
- Assert rst during the hold window at cycle 3 -> tx_valid=0 immediately. After release, a WR_DATA edge gives err (wr_armed cleared).
